case_sel_sequencer: RTL and testbench
=====================================

Name: case_sel_sequencer

Overview:
Sequencer stage that generates the select code driving a downstream case-based decoder; the decoder maps each code to output assignments. On a start request the block walks the codes 1..NUM_SEL with a valid/ready handshake, then signals completion. All combinational decode in this block must be lint-clean: every case statement has an explicit default or a full pre-assignment before the case.

Parameters:
SEL_W, 2, width of select code
NUM_SEL, 3, last code issued in a sequence (1 <= NUM_SEL <= 2**SEL_W-1)
GAP, 0, idle cycles inserted between accepted codes (0..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  begin a sequence (sampled only in IDLE)
abort_i  input  1  cancel the current sequence
sel_ready_i  input  1  downstream accepts sel_o this cycle
sel_o  output  SEL_W  select code to downstream decoder
sel_valid_o  output  1  sel_o is valid
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle pulse at sequence completion
aborted_o  output  1  one-cycle pulse when abort takes effect

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE; sel_o=0, sel_valid_o=0, busy_o=0, done_o=0, aborted_o=0; gap counter=0. Reset overrides all inputs, including mid-sequence.
- States: IDLE, ISSUE, GAP, DONE. All outputs registered.
- IDLE: sel_o=0, valid=0. start_i=1 -> ISSUE next cycle with sel_o=1, valid=1, busy=1 (latency start->first valid = 1 cycle).
- ISSUE: valid=1; sel_o held stable while sel_ready_i=0 (no code change, no valid drop).
  - Handshake (valid & ready) with sel_o<NUM_SEL: GAP=0 -> next cycle sel_o+1, valid stays 1 (back-to-back); GAP>0 -> GAP state, valid=0, counter loaded GAP-1.
  - Handshake with sel_o==NUM_SEL -> DONE, valid=0.
- GAP: valid=0; counter decrements each cycle; at 0 -> ISSUE with sel_o incremented.
- DONE: done_o=1 for exactly one cycle, busy=1; next cycle IDLE, busy=0, sel_o=0. start_i in DONE ignored.
- start_i while busy ignored; no queuing.
- abort_i in ISSUE/GAP/DONE: next cycle IDLE, sel_o=0, valid=0, busy=0, aborted_o=1 for one cycle; done_o not asserted. abort_i in IDLE: no effect, no pulse.
- Simultaneous abort_i and handshake: abort wins; code counts as accepted downstream, but no further codes issued.
- Simultaneous abort_i and start_i in IDLE: start wins (abort ignored in IDLE).
- sel_o never exceeds NUM_SEL and never wraps; code 0 is never issued with valid=1.
- Next-state case: default branch -> IDLE; illegal encodings recover to IDLE in one cycle.

Test Plan:
- Reset then start_i pulse, sel_ready_i=1, NUM_SEL=3, GAP=0 -> valid codes 1,2,3 on cycles 1-3 after start; done_o=1 on cycle 4; busy_o low on cycle 5.
- Backpressure: sel_ready_i=0 for 4 cycles while sel_o=2 -> sel_o=2, valid=1 held all 4 cycles; resumes 3 after ready.
- GAP=2, ready=1 -> valid high 1 cycle, low 2 cycles between codes; total start-to-done = 8 cycles.
- abort_i asserted with sel_o=2 valid & ready -> next cycle sel_o=0, valid=0, aborted_o=1, done_o never pulses; start_i 1 cycle later begins fresh at sel_o=1.
- rst asserted mid-GAP -> next cycle all outputs 0, state IDLE; start_i during busy (repeat pulses) -> exactly one sequence of 3 codes.
- Downstream decoder hookup: codes 1..3 decode to distinct outputs; sel_o=0 in IDLE yields the decoder's default/pre-assigned values.

Source files
------------

// File: rtl/case_sel_sequencer.sv
// Select-code sequencer: on start, presents codes 1..NUM_SEL to a downstream
// case decoder with a valid/ready handshake. Idle gaps between codes are
// optional. Completion and abort are each signalled by a one-cycle pulse.
module case_sel_sequencer #(
   parameter int SEL_W   = 2,
   parameter int NUM_SEL = 3,
   parameter int GAP     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             sel_ready_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             sel_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL);
   localparam logic [3:0]       GAP_LOAD = 4'(GAP - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;

   // Next-state and next-output decode; everything is pre-assigned before the case.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         S_IDLE: begin
            sel_d     = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            gap_cnt_d = '0;
            if (start_i) begin
               state_d = S_ISSUE;
               sel_d   = SEL_ONE;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            if (abort_i) begin
               // Abort wins over a coincident handshake; the code still counts downstream.
               state_d   = S_IDLE;
               sel_d     = '0;
               valid_d   = 1'b0;
               busy_d    = 1'b0;
               gap_cnt_d = '0;
               aborted_d = 1'b1;
            end else if (sel_ready_i) begin
               if (sel_q == SEL_LAST) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else if (GAP == 0) begin
                  sel_d = sel_q + SEL_ONE;
               end else begin
                  state_d   = S_GAP;
                  valid_d   = 1'b0;
                  gap_cnt_d = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            if (abort_i) begin
               state_d   = S_IDLE;
               sel_d     = '0;
               valid_d   = 1'b0;
               busy_d    = 1'b0;
               gap_cnt_d = '0;
               aborted_d = 1'b1;
            end else if (gap_cnt_q == '0) begin
               state_d = S_ISSUE;
               sel_d   = sel_q + SEL_ONE;
               valid_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            sel_d     = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            gap_cnt_d = '0;
            aborted_d = abort_i;
         end
         default: begin
            state_d   = S_IDLE;
            sel_d     = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            gap_cnt_d = '0;
         end
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign sel_o       = sel_q;
   assign sel_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_case_sel_sequencer.sv
// Scoreboard bench for case_sel_sequencer: two instances (back-to-back and
// gapped) share stimulus; a reference model predicts per-cycle outputs and
// the stream of accepted codes / completion / abort events.
module tb_case_sel_sequencer;

   localparam int N_A = 3, G_A = 0, W_A = 2;
   localparam int N_B = 5, G_B = 2, W_B = 3;
   localparam int EV_DONE  = 100;
   localparam int EV_ABORT = 200;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b0;
   logic [W_A-1:0] sel_a;
   logic [W_B-1:0] sel_b;
   logic valid_a, busy_a, done_a, ab_a;
   logic valid_b, busy_b, done_b, ab_b;

   always #5 clk = ~clk;

   case_sel_sequencer #(.SEL_W(W_A), .NUM_SEL(N_A), .GAP(G_A)) dut_a (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .sel_ready_i(ready),
      .sel_o(sel_a), .sel_valid_o(valid_a), .busy_o(busy_a), .done_o(done_a),
      .aborted_o(ab_a));

   case_sel_sequencer #(.SEL_W(W_B), .NUM_SEL(N_B), .GAP(G_B)) dut_b (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .sel_ready_i(ready),
      .sel_o(sel_b), .sel_valid_o(valid_b), .busy_o(busy_b), .done_o(done_b),
      .aborted_o(ab_b));

   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;
   bit fin_req = 1'b0;

   int num_c[2] = '{N_A, N_B};
   int gap_c[2] = '{G_A, G_B};

   // Reference model: code on the bus (0 = idle), gap cycles left, finishing flag, abort pulse.
   int m_code[2] = '{0, 0};
   int m_gap[2]  = '{0, 0};
   bit m_fin[2]  = '{1'b0, 1'b0};
   bit m_ab[2]   = '{1'b0, 1'b0};

   int exp_cyc[2][$];
   int exp_ev[2][$];

   function automatic int enc(int s, bit v, bit b, bit d, bit a);
      return (s << 4) | (int'(v) << 3) | (int'(b) << 2) | (int'(d) << 1) | int'(a);
   endfunction

   function automatic bit m_valid(int k);
      return (m_code[k] != 0) && (m_gap[k] == 0) && !m_fin[k];
   endfunction

   function automatic void model_step(int k, bit r, bit s, bit a, bit rd);
      bit hs;
      hs = m_valid(k) && rd;
      m_ab[k] = 1'b0;
      if (r) begin
         m_code[k] = 0; m_gap[k] = 0; m_fin[k] = 1'b0;
      end else if (m_fin[k]) begin
         m_fin[k] = 1'b0; m_code[k] = 0; m_ab[k] = a;
      end else if (m_code[k] == 0) begin
         if (s) m_code[k] = 1;
      end else if (a) begin
         m_code[k] = 0; m_gap[k] = 0; m_ab[k] = 1'b1;
      end else if (m_gap[k] > 0) begin
         m_gap[k]--;
         if (m_gap[k] == 0) m_code[k]++;
      end else if (hs) begin
         if (m_code[k] == num_c[k]) m_fin[k] = 1'b1;
         else if (gap_c[k] == 0) m_code[k]++;
         else m_gap[k] = gap_c[k];
      end
   endfunction

   // Apply one cycle of stimulus, record what each instance should show, advance the model.
   task automatic drive(bit r, bit s, bit a, bit rd);
      rst = r; start = s; abort = a; ready = rd;
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            exp_cyc[k].push_back(enc(m_code[k], m_valid(k), m_code[k] != 0, m_fin[k], m_ab[k]));
            if (m_valid(k) && rd) exp_ev[k].push_back(m_code[k]);
            if (m_fin[k]) exp_ev[k].push_back(EV_DONE);
            if (m_ab[k]) exp_ev[k].push_back(EV_ABORT);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) model_step(k, r, s, a, rd);
   endtask

   // Monitor: per-cycle output compare plus event scoreboard on handshakes and pulses.
   always @(negedge clk) begin : monitor
      int o_sel, got, want;
      bit o_v, o_b, o_d, o_a;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            o_sel = int'(sel_a); o_v = valid_a; o_b = busy_a; o_d = done_a; o_a = ab_a;
         end else begin
            o_sel = int'(sel_b); o_v = valid_b; o_b = busy_b; o_d = done_b; o_a = ab_b;
         end
         if (exp_cyc[k].size() != 0) begin
            want = exp_cyc[k].pop_front();
            got = enc(o_sel, o_v, o_b, o_d, o_a);
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL outputs dut%0d t=%0t got sel=%0d v=%0d b=%0d d=%0d a=%0d expected sel=%0d v=%0d b=%0d d=%0d a=%0d",
                        k, $time, o_sel, o_v, o_b, o_d, o_a, want >> 4, (want >> 3) & 1,
                        (want >> 2) & 1, (want >> 1) & 1, want & 1);
            end
         end
         for (int e = 0; e < 3; e++) begin
            bit hit;
            hit = (e == 0) ? (o_v === 1'b1 && ready === 1'b1) :
                  (e == 1) ? (o_d === 1'b1) : (o_a === 1'b1);
            if (hit) begin
               got = (e == 0) ? o_sel : (e == 1) ? EV_DONE : EV_ABORT;
               checks++;
               if (exp_ev[k].size() == 0) begin
                  failures++;
                  $display("FAIL event dut%0d t=%0t got %0d expected none", k, $time, got);
               end else begin
                  want = exp_ev[k].pop_front();
                  if (got != want) begin
                     failures++;
                     $display("FAIL event dut%0d t=%0t got %0d expected %0d", k, $time, got, want);
                  end
               end
            end
         end
      end
      if (fin_req) begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (exp_ev[k].size() != 0) begin
               failures++;
               $display("FAIL drain dut%0d got %0d pending events expected 0", k, exp_ev[k].size());
            end
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      armed = 1'b1;
      // Plain sequence, ready always high.
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1);
      // Backpressure while code 2 is presented.
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1);
      // Abort coincident with handshake of code 2, then a fresh start.
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1);
      // Reset while the gapped instance sits in its gap, then repeated start pulses.
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (6) drive(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1);
      // Abort in IDLE has no effect.
      repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1);
      // Randomized traffic.
      repeat (3000)
         drive($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      repeat (30) drive(1'b0, 1'b0, 1'b0, 1'b1);
      fin_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL finish monitor did not end the run");
      $fatal(1);
   end

endmodule
